handshake_demux_1xn: RTL and testbench

HANDSHAKE_DEMUX_1XN -- requirements
Module: handshake_demux_1xn

---
 rtl/handshake_demux_1xn.sv | 119 +++++++++++
 tb/tb_handshake_demux_1xn.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/handshake_demux_1xn.sv
// 1-to-N valid/ready demultiplexer with burst locking and a single output register stage.
// Beats aimed at a non-existent channel are accepted, discarded and flagged on err_drop.
module handshake_demux_1xn #(
  parameter int WIDTH   = 32,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_last,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     busy,
  output logic                     err_drop
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lock_dest_q, lock_dest_d;
  logic               buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0]   buf_data_q, buf_data_d;
  logic               buf_last_q, buf_last_d;
  logic [SEL_W-1:0]   buf_dest_q, buf_dest_d;
  logic               err_drop_q, err_drop_d;

  logic [SEL_W-1:0]   dest;
  logic               dest_ok;
  logic               drain;
  logic               xfer;
  logic               load;

  // The buffer can take a new beat whenever it is empty or draining this cycle.
  assign drain    = buf_valid_q && out_ready[buf_dest_q];
  assign in_ready = (!buf_valid_q || out_ready[buf_dest_q]) && !ARESET;
  assign xfer     = in_valid && in_ready;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    lock_dest_d = lock_dest_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_dest_d  = buf_dest_q;

    dest    = (state_q == LOCKED) ? lock_dest_q : in_sel;
    dest_ok = ({1'b0, dest} < NUM_OUT_W);
    load    = xfer && dest_ok;

    if (drain) buf_valid_d = 1'b0;
    if (load) begin
      buf_valid_d = 1'b1;
      buf_data_d  = in_data;
      buf_last_d  = in_last;
      buf_dest_d  = dest;
    end

    err_drop_d = xfer && !dest_ok;

    // Burst tracking runs on every accepted beat, including dropped ones.
    if (xfer) begin
      case (state_q)
        IDLE: if (!in_last) begin
          state_d     = LOCKED;
          lock_dest_d = in_sel;
        end
        LOCKED: if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; buf_data is reset too so out_data is zero coming out of reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      lock_dest_q <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_dest_q  <= '0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_dest_q <= lock_dest_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_dest_q  <= buf_dest_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign busy     = (state_q == LOCKED);
  assign err_drop = err_drop_q;

  always_comb begin
    out_valid = '0;
    out_last  = '0;
    out_data  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (buf_valid_q && (buf_dest_q == SEL_W'(i))) begin
        out_valid[i]               = 1'b1;
        out_last[i]                = buf_last_q;
        out_data[i*WIDTH +: WIDTH] = buf_data_q;
      end
    end
  end

endmodule

// File: tb/tb_handshake_demux_1xn.sv
// Directed bench for handshake_demux_1xn: a 4-channel instance for routing, locking,
// backpressure, streaming and reset, plus a 3-channel instance for invalid-select drops.
module tb_handshake_demux_1xn;

  logic         ACLK = 1'b0;
  logic         ARESET;

  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_last;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         busy;
  logic         err_drop;

  logic [31:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_last3;
  logic         in_valid3;
  logic         in_ready3;
  logic [95:0]  out_data3;
  logic [2:0]   out_last3;
  logic [2:0]   out_valid3;
  logic [2:0]   out_ready3;
  logic         busy3;
  logic         err_drop3;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  handshake_demux_1xn #(.WIDTH(32), .NUM_OUT(4), .SEL_W(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .err_drop(err_drop)
  );

  handshake_demux_1xn #(.WIDTH(32), .NUM_OUT(3), .SEL_W(2)) dut3 (
    .ACLK(ACLK), .ARESET(ARESET),
    .in_data(in_data3), .in_sel(in_sel3), .in_last(in_last3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_last(out_last3), .out_valid(out_valid3),
    .out_ready(out_ready3), .busy(busy3), .err_drop(err_drop3)
  );

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    int          ch;

    ARESET    = 1'b1;
    in_data   = '0; in_sel  = '0; in_last  = 1'b0; in_valid  = 1'b0;
    out_ready = 4'hF;
    in_data3  = '0; in_sel3 = '0; in_last3 = 1'b0; in_valid3 = 1'b0;
    out_ready3 = 3'h7;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 4'h0);
    check("rst_out_data",  out_data,  128'h0);
    check("rst_out_last",  out_last,  4'h0);
    check("rst_busy",      busy,      1'b0);
    check("rst_err_drop",  err_drop,  1'b0);
    check("rst_in_ready",  in_ready,  1'b0);
    ARESET = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Single beat to channel 2
    in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_sel = 2'd2; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_out_valid", out_valid, 4'b0100);
    check("single_out_data",  out_data,  {32'h0, 32'hA5A5A5A5, 64'h0});
    check("single_out_last",  out_last,  4'b0100);
    check("single_busy",      busy,      1'b0);
    tick();
    check("single_drained",   out_valid, 4'b0000);

    // Burst locked to channel 1 despite changing in_sel
    in_valid = 1'b1; in_data = 32'h11; in_sel = 2'd1; in_last = 1'b0;
    tick();
    check("burst_b1_busy",  busy,      1'b1);
    check("burst_b1_valid", out_valid, 4'b0010);
    check("burst_b1_data",  out_data[63:32], 32'h11);
    in_data = 32'h22; in_sel = 2'd3; in_last = 1'b0;
    tick();
    check("burst_b2_valid", out_valid, 4'b0010);
    check("burst_b2_data",  out_data[63:32], 32'h22);
    check("burst_b2_busy",  busy,      1'b1);
    in_data = 32'h33; in_sel = 2'd0; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    check("burst_b3_valid", out_valid, 4'b0010);
    check("burst_b3_data",  out_data[63:32], 32'h33);
    check("burst_b3_last",  out_last,  4'b0010);
    check("burst_b3_busy",  busy,      1'b0);
    tick();
    check("burst_drained",  out_valid, 4'b0000);

    // Backpressure on channel 0; other channels ready but irrelevant
    out_ready = 4'b1110;
    in_valid = 1'b1; in_data = 32'h44; in_sel = 2'd0; in_last = 1'b1;
    #1;
    check("bp_ready_empty", in_ready, 1'b1);
    tick();
    in_data = 32'h55;
    #1;
    check("bp_ready_full",  in_ready, 1'b0);
    tick();
    check("bp_hold1_valid", out_valid, 4'b0001);
    check("bp_hold1_data",  out_data[31:0], 32'h44);
    tick();
    check("bp_hold2_data",  out_data[31:0], 32'h44);
    out_ready = 4'hF;
    #1;
    check("bp_ready_release", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 4'b0001);
    check("bp_second_data",  out_data[31:0], 32'h55);
    tick();
    check("bp_drained", out_valid, 4'b0000);

    // Streaming: 8 single-beat bursts alternating ch0/ch3, no bubbles
    for (int i = 0; i < 8; i++) begin
      ch       = (i % 2 == 0) ? 0 : 3;
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      in_sel   = 2'(ch);
      in_last  = 1'b1;
      #1;
      check("stream_in_ready", in_ready, 1'b1);
      tick();
      exp_v = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      exp_d = 32'h100 + 32'(i);
      check("stream_out_valid", out_valid, exp_v);
      check("stream_out_data",  out_data[ch*32 +: 32], exp_d);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", out_valid, 4'b0000);

    // Invalid select on the 3-channel instance: 2-beat burst to channel 3
    in_valid3 = 1'b1; in_data3 = 32'hDEAD; in_sel3 = 2'd3; in_last3 = 1'b0;
    #1;
    check("inv_b1_ready", in_ready3, 1'b1);
    tick();
    check("inv_b1_err",   err_drop3,  1'b1);
    check("inv_b1_valid", out_valid3, 3'b000);
    check("inv_b1_busy",  busy3,      1'b1);
    in_data3 = 32'hBEEF; in_sel3 = 2'd0; in_last3 = 1'b1;
    #1;
    check("inv_b2_ready", in_ready3, 1'b1);
    tick();
    in_valid3 = 1'b0;
    check("inv_b2_err",   err_drop3,  1'b1);
    check("inv_b2_valid", out_valid3, 3'b000);
    check("inv_b2_busy",  busy3,      1'b0);
    tick();
    check("inv_err_clear", err_drop3,  1'b0);
    check("inv_valid_idle", out_valid3, 3'b000);

    // Reset during beat 2 of a 4-beat burst to channel 1
    in_valid = 1'b1; in_data = 32'h61; in_sel = 2'd1; in_last = 1'b0;
    tick();
    check("rmb_b1_busy", busy, 1'b1);
    in_data = 32'h62;
    ARESET  = 1'b1;
    #1;
    check("rmb_in_ready", in_ready, 1'b0);
    tick();
    check("rmb_out_valid", out_valid, 4'h0);
    check("rmb_out_data",  out_data,  128'h0);
    check("rmb_busy",      busy,      1'b0);
    ARESET = 1'b0;
    in_data = 32'h77; in_sel = 2'd2; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rmb_next_valid", out_valid, 4'b0100);
    check("rmb_next_data",  out_data[95:64], 32'h77);
    check("rmb_next_busy",  busy, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
